// File: rtl/ecc_pkg.sv
// ecc_pkg -- shared definitions for the ECC decoder scheduler.
// Holds the code-mode enum carried on req_mod*/dec_mod, the scheduler FSM
// state type and the width constants used by the interface and the RTL.
package ecc_pkg;

  localparam int unsigned CW_WIDTH   = 32;  // codeword width
  localparam int unsigned INFO_WIDTH = 26;  // decoded info width
  localparam int unsigned ERR_WIDTH  = 2;   // decoder error-count width
  localparam int unsigned MOD_WIDTH  = 2;   // code-mode field width
  localparam int unsigned LAT_CNT_W  = 3;   // holds DEC_LATENCY 1..7

  typedef enum logic [MOD_WIDTH-1:0] {
    MOD_8       = 2'b00,
    MOD_16      = 2'b01,
    MOD_32      = 2'b10,
    MOD_ILLEGAL = 2'b11
  } ecc_mod_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } ecc_state_e;

endpackage

// File: rtl/ecc_dec_sched_if.sv
// ecc_dec_sched_if -- bundle of the request, decoder and response signals.
//   req_*  : two requesters (valid/ready per requester, codeword, mode)
//   dec_*  : drive to / return from the external decoder
//   rsp_*  : single response channel with valid/ready
// Handshake rule for req and rsp: a transfer happens on a rising clk edge
// where valid and ready are both 1; a source holds its payload stable while
// valid=1 and ready=0. req_ready is a combinational accept strobe.
// slave modport: the scheduler; master modport: the environment.
interface ecc_dec_sched_if #(
  parameter int unsigned CW_W   = ecc_pkg::CW_WIDTH,
  parameter int unsigned INFO_W = ecc_pkg::INFO_WIDTH
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [CW_W-1:0]   req_data0;
  logic [CW_W-1:0]   req_data1;
  logic [1:0]        req_mod0;
  logic [1:0]        req_mod1;

  logic [CW_W-1:0]   dec_data_in;
  logic [1:0]        dec_mod;
  logic [INFO_W-1:0] dec_data_out;
  logic [1:0]        dec_num_of_errors;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [INFO_W-1:0] rsp_data;
  logic [1:0]        rsp_errors;
  logic              rsp_illegal;

  modport slave (
    input  req_valid, req_data0, req_data1, req_mod0, req_mod1,
    output req_ready,
    output dec_data_in, dec_mod,
    input  dec_data_out, dec_num_of_errors,
    output rsp_valid, rsp_id, rsp_data, rsp_errors, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_data0, req_data1, req_mod0, req_mod1,
    input  req_ready,
    input  dec_data_in, dec_mod,
    output dec_data_out, dec_num_of_errors,
    input  rsp_valid, rsp_id, rsp_data, rsp_errors, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/ecc_rr_arb2.sv
// ecc_rr_arb2 -- two-requester round-robin arbiter.
//   clk, rst : clock, active-low synchronous reset (priority back to req 0)
//   en       : arbitration allowed this cycle
//   req      : request bits
//   gnt      : one-hot grant (0 when en=0 or no request)
//   gnt_id   : index of the granted requester
// prio_q names the requester that wins a tie; it moves to the other one only
// when a grant is actually issued.
module ecc_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);
  logic prio_q, prio_d;

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    prio_d = prio_q;
    if (en) begin
      case (req)
        2'b01:   begin gnt = 2'b01; gnt_id = 1'b0; end
        2'b10:   begin gnt = 2'b10; gnt_id = 1'b1; end
        2'b11:   begin gnt = prio_q ? 2'b10 : 2'b01; gnt_id = prio_q; end
        default: ;
      endcase
      if (req != 2'b00) prio_d = ~gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) prio_q <= 1'b0;
    else      prio_q <= prio_d;
  end
endmodule

// File: rtl/ecc_dec_sched.sv
// ecc_dec_sched -- schedules two requesters onto one external ECC decoder.
//   clk, rst  : clock, active-low synchronous reset
//   bus       : ecc_dec_sched_if.slave (requests, decoder drive/return, response)
//   stats_clr, corr_cnt, uncorr_cnt : present only with ECC_DEC_SCHED_STATS_EN
//   dbg_state : current FSM state
// One transaction at a time: IDLE grants and captures, BUSY waits DEC_LATENCY
// cycles for the decoder, RESP holds the registered response until taken.
// Illegal mode skips the decoder and answers the cycle after the grant.
// Optional macro ECC_DEC_SCHED_STATS_EN adds saturating corrected /
// uncorrectable response counters updated at the response handshake.
module ecc_dec_sched
  import ecc_pkg::*;
#(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned MAX_INFO_WIDTH     = 26,
  parameter int unsigned DEC_LATENCY        = 1,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_dec_sched_if.slave       bus,
`ifdef ECC_DEC_SCHED_STATS_EN
  input  logic                 stats_clr,
  output logic [CNT_WIDTH-1:0] corr_cnt,
  output logic [CNT_WIDTH-1:0] uncorr_cnt,
`endif
  output ecc_state_e           dbg_state
);
  if (DEC_LATENCY < 1 || DEC_LATENCY > 7 || CNT_WIDTH < 1) begin : g_param_check
    $error("ecc_dec_sched: DEC_LATENCY must be 1..7 and CNT_WIDTH >= 1");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(DEC_LATENCY);

  ecc_state_e                  state_q, state_d;
  logic [MAX_CODEWORD_WIDTH-1:0] hold_data_q, hold_data_d;
  ecc_mod_e                    hold_mod_q, hold_mod_d;
  logic                        hold_id_q, hold_id_d;
  logic [LAT_CNT_W-1:0]        cnt_q, cnt_d;
  logic                        rsp_id_q, rsp_id_d;
  logic [MAX_INFO_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]                  rsp_err_q, rsp_err_d;
  logic                        rsp_ill_q, rsp_ill_d;

  logic       arb_en;
  logic [1:0] arb_gnt;
  logic       arb_id;
  logic       drive_dec;
  logic       rsp_hs;

  assign arb_en = (state_q == IDLE);

  ecc_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .req    (bus.req_valid),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_mod_d  = hold_mod_q;
    hold_id_d   = hold_id_q;
    cnt_d       = cnt_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_ill_d   = rsp_ill_q;
    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          hold_data_d = arb_id ? bus.req_data1 : bus.req_data0;
          hold_mod_d  = ecc_mod_e'(arb_id ? bus.req_mod1 : bus.req_mod0);
          hold_id_d   = arb_id;
          if (hold_mod_d == MOD_ILLEGAL) begin
            // Answer directly; the decoder never sees this codeword.
            state_d    = RESP;
            rsp_id_d   = arb_id;
            rsp_data_d = '0;
            rsp_err_d  = 2'b00;
            rsp_ill_d  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      BUSY: begin
        // Counter reaches 0 in the cycle the decoder output is valid.
        if (cnt_q == '0) begin
          state_d    = RESP;
          rsp_id_d   = hold_id_q;
          rsp_data_d = bus.dec_data_out;
          rsp_err_d  = bus.dec_num_of_errors;
          rsp_ill_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_mod_q  <= MOD_8;
      hold_id_q   <= 1'b0;
      cnt_q       <= '0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 2'b00;
      rsp_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_mod_q  <= hold_mod_d;
      hold_id_q   <= hold_id_d;
      cnt_q       <= cnt_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_ill_q   <= rsp_ill_d;
    end
  end

  // Decoder inputs stay driven through RESP so they are stable until IDLE.
  assign drive_dec       = (state_q == BUSY) || (state_q == RESP && !rsp_ill_q);
  assign bus.dec_data_in = drive_dec ? hold_data_q : '0;
  assign bus.dec_mod     = drive_dec ? hold_mod_q : MOD_8;

  // Grant strobe is suppressed while reset is asserted.
  assign bus.req_ready   = rst ? arb_gnt : 2'b00;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_errors  = rsp_err_q;
  assign bus.rsp_illegal = rsp_ill_q;
  assign rsp_hs          = (state_q == RESP) && bus.rsp_ready;
  assign dbg_state       = state_q;

`ifdef ECC_DEC_SCHED_STATS_EN
  logic [CNT_WIDTH-1:0] corr_q, corr_d, uncorr_q, uncorr_d;

  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (rsp_hs && !rsp_ill_q) begin
      if (rsp_err_q == 2'd1 && corr_q != '1)   corr_d   = corr_q + 1'b1;
      if (rsp_err_q >= 2'd2 && uncorr_q != '1) uncorr_d = uncorr_q + 1'b1;
    end
    // Clear beats a same-cycle increment.
    if (stats_clr) begin
      corr_d   = '0;
      uncorr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif
endmodule

// File: tb/tb_ecc_dec_sched.sv
// tb_ecc_dec_sched -- bench for ecc_dec_sched with a one-cycle decoder stand-in.
module tb_ecc_dec_sched;
  import ecc_pkg::*;

  localparam int CW_W   = 32;
  localparam int INFO_W = 26;
  localparam int LAT    = 1;
  localparam int CNT_W  = 2;
  localparam int EXP_W  = 1 + 1 + 2 + INFO_W;  // {id, illegal, errors, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ecc_dec_sched_if #(.CW_W(CW_W), .INFO_W(INFO_W)) bus ();
  ecc_state_e dbg_state;
`ifdef ECC_DEC_SCHED_STATS_EN
  logic             stats_clr = 1'b0;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt;
`endif

  ecc_dec_sched #(
    .MAX_CODEWORD_WIDTH (CW_W),
    .MAX_INFO_WIDTH     (INFO_W),
    .DEC_LATENCY        (LAT),
    .CNT_WIDTH          (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
`ifdef ECC_DEC_SCHED_STATS_EN
    .stats_clr  (stats_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // Decoder stand-in: info = codeword masked to the mode's data width,
  // error count taken from codeword bits [31:30]; registered (1 cycle).
  function automatic logic [INFO_W-1:0] stub_info(input logic [CW_W-1:0] cw, input logic [1:0] md);
    case (md)
      2'b00:   return {18'b0, cw[7:0]};
      2'b01:   return {10'b0, cw[15:0]};
      default: return cw[INFO_W-1:0];
    endcase
  endfunction

  always @(posedge clk) begin
    bus.dec_data_out      <= stub_info(bus.dec_data_in, bus.dec_mod);
    bus.dec_num_of_errors <= bus.dec_data_in[31:30];
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Transaction-level view: at most one request outstanding; response due
  // LAT+2 cycles after the accept (1 cycle for illegal mode).
  logic [EXP_W-1:0] exp_q[$];
  logic             m_busy = 1'b0;
  logic             m_last = 1'b1;  // last granted; 1 means requester 0 wins a tie
  logic             m_legal = 1'b0;
  logic [CW_W-1:0]  m_cw = '0;
  logic [1:0]       m_mod = 2'b00;
  int               m_lat = 0;
  int               m_elapsed = 0;
  int               m_corr = 0;
  int               m_uncorr = 0;
  localparam int    CMAX = (1 << CNT_W) - 1;

  always @(negedge clk) begin
    logic [1:0]       exp_rdy;
    logic             exp_rv;
    logic [EXP_W-1:0] e;
    logic [CW_W-1:0]  s_cw;
    logic [1:0]       s_mod;
    logic             s_id;
    #2;
    if (!rst) begin
      exp_q.delete();
      m_busy = 1'b0; m_last = 1'b1; m_corr = 0; m_uncorr = 0;
    end else begin
      exp_rdy = 2'b00;
      if (!m_busy) begin
        case (bus.req_valid)
          2'b01:   exp_rdy = 2'b01;
          2'b10:   exp_rdy = 2'b10;
          2'b11:   exp_rdy = m_last ? 2'b01 : 2'b10;
          default: exp_rdy = 2'b00;
        endcase
      end
      chk("mon_req_ready", bus.req_ready, exp_rdy);
      chk("mon_dec_data_in", bus.dec_data_in, (m_busy && m_legal) ? m_cw : '0);
      chk("mon_dec_mod", bus.dec_mod, (m_busy && m_legal) ? m_mod : 2'b00);
      if (m_busy) m_elapsed++;
      exp_rv = m_busy && (m_elapsed >= m_lat);
      chk("mon_rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv && exp_q.size() > 0)
        chk("mon_rsp_fields", {bus.rsp_id, bus.rsp_illegal, bus.rsp_errors, bus.rsp_data}, exp_q[0]);
`ifdef ECC_DEC_SCHED_STATS_EN
      chk("mon_corr_cnt", corr_cnt, m_corr);
      chk("mon_uncorr_cnt", uncorr_cnt, m_uncorr);
`endif
      if (exp_rv && bus.rsp_ready) begin
        e = exp_q.pop_front();
        m_busy = 1'b0;
        if (!e[EXP_W-2]) begin
          if (e[INFO_W+1:INFO_W] == 2'd1 && m_corr < CMAX) m_corr++;
          if (e[INFO_W+1:INFO_W] >= 2'd2 && m_uncorr < CMAX) m_uncorr++;
        end
      end
`ifdef ECC_DEC_SCHED_STATS_EN
      if (stats_clr) begin m_corr = 0; m_uncorr = 0; end
`endif
      if (exp_rdy != 2'b00) begin
        s_id  = exp_rdy[1];
        s_cw  = s_id ? bus.req_data1 : bus.req_data0;
        s_mod = s_id ? bus.req_mod1 : bus.req_mod0;
        m_busy = 1'b1; m_last = s_id; m_elapsed = 0;
        m_cw = s_cw; m_mod = s_mod; m_legal = (s_mod != 2'b11);
        m_lat = m_legal ? LAT + 2 : 1;
        if (m_legal) exp_q.push_back({s_id, 1'b0, s_cw[31:30], stub_info(s_cw, s_mod)});
        else         exp_q.push_back({s_id, 1'b1, 2'b00, {INFO_W{1'b0}}});
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]        valid;
    logic [CW_W-1:0]   d0;
    logic [1:0]        m0;
    logic [CW_W-1:0]   d1;
    logic [1:0]        m1;
    logic [1:0]        exp_rdy;
    logic              exp_ill;
    logic [1:0]        exp_err;
    logic [INFO_W-1:0] exp_data;
    int                exp_lat;
  } vec_t;
  vec_t vecs[6];

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic do_reset();
    rst = 1'b0; bus.req_valid = 2'b11; bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id", bus.rsp_id, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, '0);
    chk("rst_rsp_errors", bus.rsp_errors, 2'b00);
    chk("rst_rsp_illegal", bus.rsp_illegal, 1'b0);
    chk("rst_dec_data_in", bus.dec_data_in, '0);
    chk("rst_dec_mod", bus.dec_mod, 2'b00);
    chk("rst_state", dbg_state, IDLE);
`ifdef ECC_DEC_SCHED_STATS_EN
    chk("rst_corr_cnt", corr_cnt, 0);
    chk("rst_uncorr_cnt", uncorr_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1; bus.req_valid = 2'b00;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    bus.req_valid = v.valid; bus.rsp_ready = 1'b1;
    bus.req_data0 = v.d0; bus.req_mod0 = v.m0;
    bus.req_data1 = v.d1; bus.req_mod1 = v.m1;
    #1; cyc = 0;
    while (bus.req_ready == 2'b00 && cyc < 20) begin @(negedge clk); #1; cyc++; end
    chk({tag, "_grant"}, bus.req_ready, v.exp_rdy);
    @(negedge clk); bus.req_valid = 2'b00; #1; cyc = 1;
    while (!bus.rsp_valid && cyc < 20) begin @(negedge clk); #1; cyc++; end
    chk({tag, "_latency"}, cyc, v.exp_lat);
    chk({tag, "_rsp_id"}, bus.rsp_id, v.exp_rdy[1]);
    chk({tag, "_rsp_illegal"}, bus.rsp_illegal, v.exp_ill);
    chk({tag, "_rsp_errors"}, bus.rsp_errors, v.exp_err);
    chk({tag, "_rsp_data"}, bus.rsp_data, v.exp_data);
    @(negedge clk);
  endtask

  task automatic drain();
    int cyc = 0;
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b1;
    @(negedge clk); #3;
    while (m_busy && cyc < 50) begin @(negedge clk); #3; cyc++; end
    if (cyc >= 50) chk("drain_timeout", 1, 0);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, n;
    logic order[4];
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
    bus.req_data0 = '0; bus.req_data1 = '0; bus.req_mod0 = 2'b00; bus.req_mod1 = 2'b00;

    //            valid  d0             m0     d1             m1     rdy    ill   err    data            lat
    vecs[0] = '{2'b01, 32'h4000_1234, 2'b01, 32'h0000_0000, 2'b00, 2'b01, 1'b0, 2'b01, 26'h000_1234, 3};
    vecs[1] = '{2'b10, 32'h0000_0000, 2'b00, 32'h8123_4567, 2'b00, 2'b10, 1'b0, 2'b10, 26'h000_0067, 3};
    vecs[2] = '{2'b10, 32'h0000_0000, 2'b00, 32'hFFFF_FFFF, 2'b11, 2'b10, 1'b1, 2'b00, 26'h000_0000, 1};
    vecs[3] = '{2'b01, 32'hC3FF_FFFF, 2'b10, 32'h0000_0000, 2'b00, 2'b01, 1'b0, 2'b11, 26'h3FF_FFFF, 3};
    vecs[4] = '{2'b11, 32'h1111_1111, 2'b00, 32'h0000_ABCD, 2'b01, 2'b10, 1'b0, 2'b00, 26'h000_ABCD, 3};
    vecs[5] = '{2'b11, 32'h4000_00FF, 2'b00, 32'h2222_2222, 2'b10, 2'b01, 1'b0, 2'b01, 26'h000_00FF, 3};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held valid: grants alternate starting at 0.
    do_reset();
    bus.req_data0 = 32'h4000_0011; bus.req_mod0 = 2'b01;
    bus.req_data1 = 32'h8000_0022; bus.req_mod1 = 2'b10;
    bus.req_valid = 2'b11; bus.rsp_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 100) begin
      #1;
      if (bus.req_ready != 2'b00) begin order[n] = bus.req_ready[1]; n++; end
      @(negedge clk); cyc++;
    end
    chk("rr_grant_count", n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), order[i], i % 2);
    drain();

    // Response back-pressure for 5 cycles, then earliest re-accept.
    bus.req_data0 = 32'h4000_0055; bus.req_mod0 = 2'b01;
    bus.req_valid = 2'b11; bus.rsp_ready = 1'b0;
    #1; cyc = 0;
    while (bus.req_ready == 2'b00 && cyc < 20) begin @(negedge clk); #1; cyc++; end
    chk("bp_grant", bus.req_ready, 2'b01);
    cyc = 0;
    while (!bus.rsp_valid && cyc < 20) begin @(negedge clk); #1; cyc++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_req_ready", bus.req_ready, 2'b00);
      chk("bp_rsp_hold", {bus.rsp_id, bus.rsp_illegal, bus.rsp_errors, bus.rsp_data},
          {1'b0, 1'b0, 2'b01, 26'h000_0055});
    end
    @(negedge clk); bus.rsp_ready = 1'b1; #1;
    chk("bp_hs_req_ready", bus.req_ready, 2'b00);
    @(negedge clk); bus.rsp_ready = 1'b0; #1;
    chk("bp_next_accept", bus.req_ready, 2'b10);
    drain();

    // Reset in BUSY drops the transaction and restores priority to 0.
    bus.req_valid = 2'b01; #1;
    chk("rb_grant", bus.req_ready, 2'b01);
    @(negedge clk); bus.req_valid = 2'b00; rst = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("rb_state_idle", dbg_state, IDLE);
    for (int i = 0; i < 4; i++) begin
      chk("rb_no_rsp", bus.rsp_valid, 1'b0);
      @(negedge clk); #1;
    end
    @(negedge clk); bus.req_valid = 2'b11; #1;
    chk("rb_grant_after", bus.req_ready, 2'b01);
    drain();

`ifdef ECC_DEC_SCHED_STATS_EN
    // Saturation at 3 and clear winning over a same-cycle increment.
    do_reset();
    for (int i = 0; i < 5; i++)
      run_vec('{2'b01, 32'h4000_0077, 2'b00, 32'h0, 2'b00, 2'b01, 1'b0, 2'b01, 26'h000_0077, 3}, "sat");
    #1; chk("sat_corr_cnt", corr_cnt, 2'd3);
    chk("sat_uncorr_cnt", uncorr_cnt, 2'd0);
    @(negedge clk);
    bus.req_valid = 2'b01; bus.rsp_ready = 1'b0;
    @(negedge clk); bus.req_valid = 2'b00; #1; cyc = 0;
    while (!bus.rsp_valid && cyc < 20) begin @(negedge clk); #1; cyc++; end
    bus.rsp_ready = 1'b1; stats_clr = 1'b1;
    @(negedge clk); bus.rsp_ready = 1'b0; stats_clr = 1'b0; #1;
    chk("clr_corr_cnt", corr_cnt, 2'd0);
    chk("clr_uncorr_cnt", uncorr_cnt, 2'd0);
    drain();
`endif

    // Randomized traffic checked by the scoreboard.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 250) != 0);
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.req_data0 = $urandom;
      bus.req_data1 = $urandom;
      bus.req_mod0  = 2'($urandom_range(0, 3));
      bus.req_mod1  = 2'($urandom_range(0, 3));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ECC_DEC_SCHED_STATS_EN
      stats_clr     = ($urandom_range(0, 60) == 0);
`endif
    end
    @(negedge clk);
    rst = 1'b1;
`ifdef ECC_DEC_SCHED_STATS_EN
    stats_clr = 1'b0;
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ecc_dec_sched.md
ECC_DEC_SCHED -- requirements
Module: ecc_dec_sched

Interface
REQ-001 Parameters SHALL be MAX_CODEWORD_WIDTH, 32, codeword width; MAX_INFO_WIDTH, 26, info width; DEC_LATENCY, 1, decoder input-to-registered-output cycles (1..7); CNT_WIDTH, 16, statistics counter width.
REQ-002 Ports SHALL be: clk  in  1  clock; rst  in  1  reset, active-low synchronous to clk.
REQ-003 req_valid  in  2  per-requester request valid; req_ready  out  2  per-requester accept strobe.
REQ-004 req_data0/req_data1  in  MAX_CODEWORD_WIDTH  codewords; req_mod0/req_mod1  in  2  code mode (00=8b, 01=16b, 10=32b, 11 illegal).
REQ-005 dec_data_in  out  MAX_CODEWORD_WIDTH and dec_mod  out  2 drive the decoder; dec_data_out  in  MAX_INFO_WIDTH and dec_num_of_errors  in  2 return from it.
REQ-006 rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1  granted requester; rsp_data  out  MAX_INFO_WIDTH; rsp_errors  out  2; rsp_illegal  out  1.
REQ-007 With ECC_DEC_SCHED_STATS_EN: stats_clr  in  1; corr_cnt  out  CNT_WIDTH; uncorr_cnt  out  CNT_WIDTH.

Function
REQ-008 FSM SHALL have states IDLE, BUSY, RESP; exactly one transaction in flight.
REQ-009 IDLE with any req_valid: grant one requester, assert its req_ready combinationally that cycle (cycle A), capture data/mod/id into holding registers.
REQ-010 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; pointer updates only on a grant.
REQ-011 req_ready SHALL be 0 in BUSY and RESP and for the non-granted requester; at most one bit set.
REQ-012 Legal mod: IDLE -> BUSY; dec_data_in/dec_mod driven from holding registers from A+1, held stable until return to IDLE; 0 otherwise.
REQ-013 BUSY SHALL load a counter with DEC_LATENCY at entry, sample dec_data_out/dec_num_of_errors at cycle A+1+DEC_LATENCY, then go to RESP; rsp_valid rises at A+2+DEC_LATENCY.
REQ-014 Illegal mod (11): IDLE -> RESP directly; decoder not driven; rsp_valid at A+1 with rsp_illegal=1, rsp_data=0, rsp_errors=0.
REQ-015 RESP: rsp_* registered and stable while rsp_valid=1 and rsp_ready=0; on rsp_valid&rsp_ready go to IDLE, rsp_valid=0 next cycle.
REQ-016 A new request SHALL NOT be accepted in the handshake cycle; earliest next accept is the cycle after (IDLE).
REQ-017 dec_num_of_errors value 3 SHALL be passed through unchanged and counted as uncorrectable.

Reset
REQ-018 rst=0 at any edge, including mid-BUSY/RESP: state IDLE, in-flight transaction dropped without response, rr pointer to requester 0.
REQ-019 Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_errors=0, rsp_illegal=0, dec_data_in=0, dec_mod=0, counters=0.

Configuration
REQ-020 Macro ECC_DEC_SCHED_STATS_EN: defined -> corr_cnt (+1 per response with errors=1) and uncorr_cnt (+1 per response with errors>=2), incremented at the handshake, saturating at all-ones, illegal responses not counted.
REQ-021 stats_clr=1 SHALL zero both counters next cycle, winning over a simultaneous increment.
REQ-022 Macro undefined -> stats ports and counters absent; all other behaviour identical.

Structure
REQ-023 Shared package ecc_pkg SHALL hold the mode enum (MOD_8, MOD_16, MOD_32, MOD_ILLEGAL), the FSM state typedef, and width constants.
REQ-024 Round-robin grant logic SHALL be one sub-module ecc_rr_arb2 (2 requesters, pointer register inside); decoder instantiated outside this block.

Verification
REQ-025 Req0 valid alone, mod=01, codeword with 1 flipped bit, DEC_LATENCY=1, rsp_ready=1 -> req_ready[0] at cycle 0, rsp_valid at cycle 3, rsp_id=0, rsp_errors=1, corrected data.
REQ-026 Both valid continuously, 4 transactions -> grant order 0,1,0,1; no req_ready during BUSY/RESP.
REQ-027 Req1 mod=11 -> rsp_valid at cycle 1, rsp_illegal=1, rsp_data=0, dec_mod stays 0, counters unchanged.
REQ-028 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req_ready=0; release -> IDLE, next accept one cycle later.
REQ-029 rst=0 during BUSY -> next cycle IDLE, rsp_valid never asserted, following grant goes to requester 0.
REQ-030 STATS_EN, CNT_WIDTH=2: 5 single-error responses -> corr_cnt saturates at 3; stats_clr with simultaneous increment -> 0.
